// File: rtl/ccff_chain_loader.sv
// Streams bitstream words LSB-first into a configuration flip-flop chain,
// optionally comparing the chain's tail against a re-sent bitstream.
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  mm_q, mm_d;
    logic              err_q, err_d;

    logic shifting;
    logic handshake;
    logic miss;

    // An abort in SHIFT suppresses that cycle's shift, so the enable is gated by it.
    assign shifting  = (state_q == SHIFT) && !abort;
    assign handshake = s_valid && s_ready;
    assign miss      = shifting && mode_q && (ccff_tail != shreg_q[0]);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        bit_cnt_d = bit_cnt_q;
        mm_d      = mm_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = verify;
                    bit_cnt_d = '0;
                    mm_d      = '0;
                    err_d     = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (handshake) begin
                    shreg_d = s_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    idx_d     = idx_q + IDX_W'(1);
                    if (miss) begin
                        err_d = 1'b1;
                        if (mm_q != '1) begin
                            mm_d = mm_q + CNT_W'(1);
                        end
                    end
                    // Chain end takes priority so surplus bits of the last word are dropped.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            shreg_q   <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            mm_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            bit_cnt_q <= bit_cnt_d;
            mm_q      <= mm_d;
            err_q     <= err_d;
        end
    end

    assign s_ready       = (state_q == FETCH) && !abort;
    assign ccff_shift_en = shifting;
    assign ccff_head     = shifting && shreg_q[0];
    assign busy          = (state_q == FETCH) || (state_q == SHIFT);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign mismatch_cnt  = mm_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16- and 12-bit chains, 8-bit words)
// driving behavioural chain models, checked against a bit-stream scoreboard.
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s[2], start_s[2], verify_s[2], abort_s[2], s_valid_s[2];
    logic       s_ready_s[2], head_s[2], sen_s[2], tail_s[2], busy_s[2], done_s[2], err_s[2];
    logic [7:0]  s_data_s[2];
    logic [15:0] mm_s[2];

    logic [15:0] chain[2] = '{16'h0, 16'h0};
    logic [15:0] exp_bits[2];
    logic [15:0] exp_mm[2];
    logic        exp_err[2];
    logic [15:0] seen[2];
    int          shift_k[2];
    int          done_cnt[2];
    logic        prev_sen[2];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(16), .CNT_W(16)) dut16 (
        .prog_clk(clk), .pReset(rst_s[0]), .start(start_s[0]), .verify(verify_s[0]),
        .abort(abort_s[0]), .s_data(s_data_s[0]), .s_valid(s_valid_s[0]),
        .s_ready(s_ready_s[0]), .ccff_head(head_s[0]), .ccff_shift_en(sen_s[0]),
        .ccff_tail(tail_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]),
        .mismatch_cnt(mm_s[0])
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12), .CNT_W(16)) dut12 (
        .prog_clk(clk), .pReset(rst_s[1]), .start(start_s[1]), .verify(verify_s[1]),
        .abort(abort_s[1]), .s_data(s_data_s[1]), .s_valid(s_valid_s[1]),
        .s_ready(s_ready_s[1]), .ccff_head(head_s[1]), .ccff_shift_en(sen_s[1]),
        .ccff_tail(tail_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]),
        .mismatch_cnt(mm_s[1])
    );

    function automatic int cl(input int u);
        return (u == 0) ? 16 : 12;
    endfunction

    function automatic logic [15:0] mask(input int u);
        return 16'((32'd1 << cl(u)) - 1);
    endfunction

    // Chain image as "bit k of the last pass": bit k sits k places from the tail.
    function automatic logic [15:0] img(input int u);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < cl(u); k++) r[k] = chain[u][cl(u)-1-k];
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural configuration chains.
    assign tail_s[0] = chain[0][15];
    assign tail_s[1] = chain[1][11];
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++)
            if (sen_s[u]) chain[u] <= {chain[u][14:0], head_s[u]};
    end

    // Per-cycle scoreboard: every enabled shift must carry the next bitstream bit.
    always @(negedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            if (start_s[u] && !busy_s[u] && !done_s[u] && !rst_s[u]) begin
                shift_k[u] = 0;
                seen[u]    = '0;
            end
            if (sen_s[u]) begin
                check("shift_while_busy", busy_s[u], 1);
                if (shift_k[u] < cl(u)) begin
                    check("head_bit", head_s[u], exp_bits[u][shift_k[u]]);
                    seen[u][shift_k[u]] = head_s[u];
                end else begin
                    check("extra_shift", shift_k[u], cl(u) - 1);
                end
                shift_k[u]++;
            end else begin
                check("head_zero_idle", head_s[u], 0);
            end
            if (done_s[u]) begin
                done_cnt[u]++;
                check("done_not_busy", busy_s[u], 0);
                check("done_after_last_shift", prev_sen[u], 1);
                check("shift_count", shift_k[u], cl(u));
                check("done_err", err_s[u], exp_err[u]);
                check("done_mismatch", mm_s[u], exp_mm[u]);
            end
            prev_sen[u] = sen_s[u];
        end
    end

    task automatic run_pass(input int u, input bit v, input logic [7:0] w0, input logic [7:0] w1,
                            input int stall_n, input int abort_at, input int restart_at,
                            input int reset_at, input int mid_mm);
        int idx, hs, stall_cnt, d0;
        bit fin, abort_pend, reset_pend, abort_done, restart_done, reset_done;
        bit stalling, do_abort, do_reset, do_restart;
        logic [15:0] bits;
        bits = {w1, w0};
        exp_bits[u] = bits;
        exp_mm[u]   = v ? 16'($countones((bits ^ img(u)) & mask(u))) : 16'd0;
        exp_err[u]  = v && (exp_mm[u] != 16'd0);
        idx = 0; hs = 0; stall_cnt = 0; d0 = done_cnt[u];
        fin = 0; abort_pend = 0; reset_pend = 0;
        abort_done = 0; restart_done = 0; reset_done = 0;
        @(negedge clk); start_s[u] = 1'b1; verify_s[u] = v;
        @(negedge clk);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            start_s[u] = 1'b0; verify_s[u] = 1'b0; abort_s[u] = 1'b0; rst_s[u] = 1'b0;
            stalling = (idx == 1) && (shift_k[u] == 8) && (stall_cnt < stall_n);
            if (stalling) begin
                s_valid_s[u] = 1'b0;
                stall_cnt++;
            end else if (idx < 2) begin
                s_valid_s[u] = 1'b1;
                s_data_s[u]  = (idx == 0) ? w0 : w1;
            end else begin
                s_valid_s[u] = 1'b0;
            end
            do_abort   = (abort_at >= 0) && !abort_done && (shift_k[u] == abort_at);
            do_reset   = (reset_at >= 0) && !reset_done && (shift_k[u] == reset_at);
            do_restart = (restart_at >= 0) && !restart_done && (shift_k[u] == restart_at);
            if (do_abort)   begin abort_s[u] = 1'b1; abort_done = 1; end
            if (do_reset)   begin rst_s[u] = 1'b1; reset_done = 1; end
            if (do_restart) begin start_s[u] = 1'b1; verify_s[u] = 1'b1; restart_done = 1; end
            #2;
            if (abort_pend) begin
                check("abort_idle_busy", busy_s[u], 0);
                check("abort_err", err_s[u], 1);
                check("abort_shift_en", sen_s[u], 0);
                check("abort_s_ready", s_ready_s[u], 0);
                fin = 1;
            end else if (reset_pend) begin
                check("reset_busy", busy_s[u], 0);
                check("reset_shift_en", sen_s[u], 0);
                check("reset_mismatch", mm_s[u], 0);
                check("reset_s_ready", s_ready_s[u], 0);
                check("reset_err", err_s[u], 0);
                check("reset_done", done_s[u], 0);
                fin = 1;
            end else if (done_cnt[u] != d0) begin
                fin = 1;
            end else begin
                if (stalling) begin
                    check("stall_s_ready", s_ready_s[u], 1);
                    check("stall_shift_en", sen_s[u], 0);
                    check("stall_busy", busy_s[u], 1);
                    check("stall_bit_cnt", shift_k[u], 8);
                end
                if (do_abort) begin
                    check("abort_no_shift", sen_s[u], 0);
                    abort_pend = 1;
                end
                if (do_reset) begin
                    check("mid_mismatch", mm_s[u], mid_mm);
                    check("mid_err", err_s[u], mid_mm != 0);
                    reset_pend = 1;
                end
                if (s_valid_s[u] && s_ready_s[u] && !do_abort && !do_reset) begin
                    idx++;
                    hs++;
                end
            end
            if (!fin) @(negedge clk);
        end
        start_s[u] = 1'b0; verify_s[u] = 1'b0; abort_s[u] = 1'b0; rst_s[u] = 1'b0;
        s_valid_s[u] = 1'b0;
        if (!fin) check("pass_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #2;
        if (abort_pend || reset_pend) begin
            check("no_done_pulse", done_cnt[u], d0);
        end else begin
            check("one_done_pulse", done_cnt[u], d0 + 1);
            check("handshakes", hs, 2);
            check("err_held", err_s[u], exp_err[u]);
            check("mismatch_held", mm_s[u], exp_mm[u]);
            check("idle_after_pass", busy_s[u], 0);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; start_s[u] = 1'b0; verify_s[u] = 1'b0; abort_s[u] = 1'b0;
            s_valid_s[u] = 1'b0; s_data_s[u] = 8'h00;
            exp_bits[u] = '0; exp_mm[u] = '0; exp_err[u] = 1'b0;
            seen[u] = '0; shift_k[u] = 0; done_cnt[u] = 0; prev_sen[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #2;
        for (int u = 0; u < 2; u++) begin
            check("rst_s_ready", s_ready_s[u], 0);
            check("rst_head", head_s[u], 0);
            check("rst_shift_en", sen_s[u], 0);
            check("rst_busy", busy_s[u], 0);
            check("rst_done", done_s[u], 0);
            check("rst_err", err_s[u], 0);
            check("rst_mismatch", mm_s[u], 0);
        end
        @(negedge clk);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        repeat (2) @(negedge clk);

        // 16-bit chain: basic load, then two verify passes.
        run_pass(0, 0, 8'hA5, 8'h3C, 0, -1, -1, -1, 0);
        check("load_head_stream", seen[0], 16'h3CA5);
        check("load_chain_image", img(0), 16'h3CA5);
        run_pass(0, 1, 8'hA5, 8'h3C, 0, -1, -1, -1, 0);
        check("verify_ok_mismatch", mm_s[0], 0);
        check("verify_ok_err", err_s[0], 0);
        run_pass(0, 1, 8'hA4, 8'h3C, 0, -1, -1, -1, 0);
        check("verify_bad_mismatch", mm_s[0], 1);
        check("verify_bad_err", err_s[0], 1);

        // Back-pressure before the second word, abort, then a clean reload with a stray start.
        run_pass(0, 0, 8'h5A, 8'hC3, 5, -1, -1, -1, 0);
        check("stall_chain_image", img(0), 16'hC35A);
        run_pass(0, 0, 8'h11, 8'h22, 0, 7, -1, -1, 0);
        check("abort_err_sticky", err_s[0], 1);
        run_pass(0, 0, 8'h0F, 8'hF0, 0, -1, 3, -1, 0);
        check("reload_err_cleared", err_s[0], 0);
        check("reload_chain_image", img(0), 16'hF00F);

        // Verify pass with four mismatches in bits 4..7, cut short by reset.
        run_pass(0, 1, 8'hFF, 8'hF0, 0, -1, -1, 10, 4);

        // 12-bit chain: partial final word, verify match and all-zero mismatch.
        run_pass(1, 0, 8'hFF, 8'h0F, 0, -1, -1, -1, 0);
        check("partial_head_stream", seen[1], 16'h0FFF);
        check("partial_chain_image", img(1), 16'h0FFF);
        run_pass(1, 1, 8'hFF, 8'h0F, 0, -1, -1, -1, 0);
        check("partial_verify_ok", mm_s[1], 0);
        run_pass(1, 1, 8'h00, 8'h00, 0, -1, -1, -1, 0);
        check("partial_verify_all_bad", mm_s[1], 12);
        check("partial_verify_err", err_s[1], 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
